// File: rtl/logic_pack_pkg.sv
// Shared types and helpers for the single-bit logic packer.
// Provides the packer FSM encoding, sequence width and count-width helper.
package logic_pack_pkg;

    typedef enum logic {
        FILL,
        PEND
    } state_t;

    localparam int SEQ_W = 4;

    // Bits needed to hold a count of 0..w inclusive.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/logic_popcount.sv
// Combinational ones count of a WIDTH-bit word.
// Ports: bits (word in), ones (number of set bits, 0..WIDTH).
module logic_popcount
    import logic_pack_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]          bits,
    output logic [cnt_w(WIDTH)-1:0]   ones
);

    localparam int OW = cnt_w(WIDTH);

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + OW'(bits[i]);
        end
    end

endmodule

// File: rtl/logic_bit_packer.sv
// Packs WIDTH consecutive (a_bit, c_bit) samples into parallel words.
// Ports: clk, rst_n; in_valid/in_ready/a_bit/c_bit sample input;
//        out_valid/out_ready handshake with out_a, out_c, out_par_a,
//        out_xnor_c, out_ones and out_seq word outputs.
module logic_bit_packer
    import logic_pack_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      a_bit,
    input  logic                      c_bit,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_a,
    output logic [WIDTH-1:0]          out_c,
    output logic                      out_par_a,
    output logic                      out_xnor_c,
    output logic [cnt_w(WIDTH)-1:0]   out_ones,
    output logic [SEQ_W-1:0]          out_seq
);

    localparam int IW = $clog2(WIDTH);
    localparam int OW = cnt_w(WIDTH);

    state_t           state;
    state_t           state_nx;
    logic [IW-1:0]    cnt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_c;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_c;
    logic [OW-1:0]    ones;
    logic             in_acc;
    logic             last;
    logic             slot_free;
    logic             load;

    assign in_ready  = (state == FILL);
    assign in_acc    = in_valid && in_ready;
    assign last      = (cnt == IW'(WIDTH - 1));
    assign slot_free = !out_valid || out_ready;

    // Each bit position is overwritten once per word, so the shift
    // registers never need clearing between words. In PEND no sample
    // is accepted, so nxt_* equals the held complete word.
    always_comb begin
        nxt_a = sh_a;
        nxt_c = sh_c;
        if (in_acc) begin
            nxt_a[cnt] = a_bit;
            nxt_c[cnt] = c_bit;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            FILL: begin
                if (in_acc && last) begin
                    if (slot_free) begin
                        load = 1'b1;
                    end else begin
                        state_nx = PEND;
                    end
                end
            end
            PEND: begin
                if (slot_free) begin
                    load     = 1'b1;
                    state_nx = FILL;
                end
            end
        endcase
    end

    logic_popcount #(
        .WIDTH (WIDTH)
    ) u_pop (
        .bits (nxt_c),
        .ones (ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
            cnt   <= '0;
            sh_a  <= '0;
            sh_c  <= '0;
        end else begin
            state <= state_nx;
            sh_a  <= nxt_a;
            sh_c  <= nxt_c;
            if (in_acc) begin
                cnt <= last ? '0 : cnt + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_a      <= '0;
            out_c      <= '0;
            out_par_a  <= 1'b0;
            out_xnor_c <= 1'b0;
            out_ones   <= '0;
            out_seq    <= '0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_a      <= nxt_a;
            out_c      <= nxt_c;
            out_par_a  <= ^nxt_a;
            out_xnor_c <= ~^nxt_c;
            out_ones   <= ones;
            out_seq    <= out_seq + SEQ_W'(1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_logic_bit_packer.sv
// Self-checking bench for logic_bit_packer (WIDTH=8).
// Transaction-level model: word queue, occupancy gives ready/valid.
module tb_logic_bit_packer;

    localparam int W  = 8;
    localparam int OW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          a_bit = 1'b0;
    logic          c_bit = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_a;
    logic [W-1:0]  out_c;
    logic          out_par_a;
    logic          out_xnor_c;
    logic [OW-1:0] out_ones;
    logic [3:0]    out_seq;

    logic_bit_packer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_bit      (a_bit),
        .c_bit      (c_bit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_c      (out_c),
        .out_par_a  (out_par_a),
        .out_xnor_c (out_xnor_c),
        .out_ones   (out_ones),
        .out_seq    (out_seq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] c;
        int           seq;
    } word_t;

    word_t        q[$];
    logic [W-1:0] pa;
    logic [W-1:0] pc;
    int           np;
    int           seqn;
    int           vecs;
    int           errs;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int n;
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        if (q.size() > 0) begin
            n = $countones(q[0].c);
            chk("out_a", 64'(out_a), 64'(q[0].a));
            chk("out_c", 64'(out_c), 64'(q[0].c));
            chk("out_par_a", 64'(out_par_a), 64'($countones(q[0].a) % 2));
            chk("out_xnor_c", 64'(out_xnor_c), 64'(n % 2 == 0));
            chk("out_ones", 64'(out_ones), 64'(n));
            chk("out_seq", 64'(out_seq), 64'(q[0].seq));
        end
    endtask

    // One clock: acceptance decided from the model's own occupancy.
    task automatic cycle();
        bit ai;
        bit ao;
        ai = in_valid && (q.size() < 2);
        ao = out_ready && (q.size() > 0);
        @(posedge clk);
        if (ao) void'(q.pop_front());
        if (ai) begin
            pa[np] = a_bit;
            pc[np] = c_bit;
            np++;
            if (np == W) begin
                seqn = (seqn + 1) % 16;
                q.push_back('{pa, pc, seqn});
                np = 0;
            end
        end
        #1;
        check_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        np = 0;
        seqn = 0;
        pa = '0;
        pc = '0;
        for (int i = 0; i < 4; i++) begin
            in_valid = ~in_valid;
            a_bit = 1'b1;
            c_bit = 1'b1;
            @(posedge clk);
            #1;
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_out_a", 64'(out_a), 64'd0);
            chk("rst_out_c", 64'(out_c), 64'd0);
            chk("rst_par", 64'(out_par_a), 64'd0);
            chk("rst_xnor", 64'(out_xnor_c), 64'd0);
            chk("rst_ones", 64'(out_ones), 64'd0);
            chk("rst_seq", 64'(out_seq), 64'd0);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic send(input logic a, input logic c);
        in_valid = 1'b1;
        a_bit = a;
        c_bit = c;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ta;
        vecs = 0;
        errs = 0;
        np = 0;
        seqn = 0;
        pa = '0;
        pc = '0;

        // Reset with in_valid toggling
        do_reset();

        // Known word 8'h8D / 8'hFF
        out_ready = 1'b1;
        ta = 8'h8D;
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1;
            a_bit = ta[i];
            c_bit = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        chk("t2_out_a", 64'(out_a), 64'h8D);
        chk("t2_par", 64'(out_par_a), 64'd0);
        chk("t2_out_c", 64'(out_c), 64'hFF);
        chk("t2_xnor", 64'(out_xnor_c), 64'd1);
        chk("t2_ones", 64'(out_ones), 64'd8);
        chk("t2_seq", 64'(out_seq), 64'd1);
        chk("t2_valid", 64'(out_valid), 64'd1);

        // Backpressure: 16 samples with out_ready low
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            send(1'($urandom), 1'($urandom));
            in_valid = 1'b1;
        end
        in_valid = 1'b0;
        chk("t3_in_ready_low", 64'(in_ready), 64'd0);
        chk("t3_seq_held", 64'(out_seq), 64'd1);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("t3_seq2", 64'(out_seq), 64'd2);
        chk("t3_valid", 64'(out_valid), 64'd1);
        chk("t3_in_ready_back", 64'(in_ready), 64'd1);
        cycle();

        // 17 words back to back: sequence wraps
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 17 * W; i++) begin
            a_bit = 1'($urandom);
            c_bit = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        chk("t4_seq_wrap", 64'(out_seq), 64'd1);
        chk("t4_in_ready", 64'(in_ready), 64'd1);

        // Reset mid-word, then a fresh word
        for (int i = 0; i < 5; i++) send(1'b1, 1'b1);
        do_reset();
        for (int i = 0; i < W; i++) send(1'(i % 2), 1'(i < 3));
        chk("t5_out_a", 64'(out_a), 64'hAA);
        chk("t5_out_c", 64'(out_c), 64'h07);
        chk("t5_seq", 64'(out_seq), 64'd1);

        // Random gaps and random backpressure
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            a_bit = 1'($urandom);
            c_bit = 1'($urandom);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        chk("drain_valid", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
